// File: rtl/acl_spi_pkg.sv
// acl_spi_pkg: sequencer states, ADXL362 command bytes and frame sizes
package acl_spi_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        CFG_FRAME,
        GAP,
        WAIT,
        RD_FRAME
    } state_e;

    localparam logic [7:0] CMD_WRITE     = 8'h0A;
    localparam logic [7:0] CMD_READ      = 8'h0B;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] PWR_MEASURE   = 8'h02;
    localparam logic [7:0] REG_XDATA     = 8'h08;

    localparam logic [2:0] CFG_BYTES = 3'd3;
    localparam logic [2:0] RD_BYTES  = 3'd5;

    // Byte idx of the config write frame (cfg=1) or the XYZ read frame (cfg=0)
    function automatic logic [7:0] frame_byte(input logic cfg, input logic [2:0] idx);
        if (cfg)
            return idx == 3'd0 ? CMD_WRITE : idx == 3'd1 ? REG_POWER_CTL : PWR_MEASURE;
        return idx == 3'd0 ? CMD_READ : idx == 3'd1 ? REG_XDATA : 8'h00;
    endfunction

endpackage

// File: rtl/acl_spi_shifter.sv
// acl_spi_shifter: one SPI mode-0 frame of n_bytes_i bytes, MSB first, CSN/SCLK/MOSI registered
module acl_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       pclk_i,
    input  logic       presetn_i,
    input  logic       start_i,
    input  logic [2:0] n_bytes_i,
    input  logic [7:0] tx_byte_i,
    output logic [2:0] tx_idx_o,
    output logic [7:0] rx_byte_o,
    output logic [2:0] rx_idx_o,
    output logic       rx_valid_o,
    output logic       done_o,
    input  logic       miso_i,
    output logic       mosi_o,
    output logic       sclk_o,
    output logic       csn_o
);
    import acl_spi_pkg::*;

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic          csn_q, sclk_q, mosi_q, rx_valid_q;
    logic [DW-1:0] div_q;
    logic [7:0]    half_q, half_n, two_n;
    logic [2:0]    nb_q, bit_q, byte_q, rx_idx_q;
    logic [6:0]    tx_sr_q, rx_sr_q;
    logic [7:0]    rx_byte_q, rx_next;
    logic          tick, rise, fall;

    // Half-period events: odd half n raises SCLK, even lowers it, half 2N+1 ends the frame
    always_comb begin
        two_n   = {1'b0, nb_q, 4'b0000};
        half_n  = half_q + 8'd1;
        tick    = !csn_q && div_q == DW'(CLK_DIV - 1);
        done_o  = tick && half_n == two_n + 8'd1;
        rise    = tick && half_n[0] && !done_o;
        fall    = tick && !half_n[0];
        rx_next = {rx_sr_q, miso_i};
    end

    // The top supplies the byte that will be loaded next: byte 0 at start, then one ahead
    assign tx_idx_o   = csn_q ? 3'd0 : byte_q + 3'd1;
    assign rx_byte_o  = rx_byte_q;
    assign rx_idx_o   = rx_idx_q;
    assign rx_valid_o = rx_valid_q;
    assign mosi_o     = mosi_q;
    assign sclk_o     = sclk_q;
    assign csn_o      = csn_q;

    // Frame engine: MOSI moves with CSN fall and SCLK falls, MISO is taken with SCLK rise
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            csn_q      <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            div_q      <= '0;
            half_q     <= '0;
            nb_q       <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_byte_q  <= '0;
            rx_idx_q   <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (start_i && csn_q) begin
                csn_q   <= 1'b0;
                div_q   <= '0;
                half_q  <= '0;
                nb_q    <= n_bytes_i;
                bit_q   <= '0;
                byte_q  <= '0;
                tx_sr_q <= tx_byte_i[6:0];
                mosi_q  <= tx_byte_i[7];
            end else if (!csn_q) begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick)
                    half_q <= half_n;
                if (done_o) begin
                    csn_q  <= 1'b1;
                    mosi_q <= 1'b0;
                end else if (rise) begin
                    sclk_q  <= 1'b1;
                    rx_sr_q <= rx_next[6:0];
                    if (bit_q == 3'd7) begin
                        rx_byte_q  <= rx_next;
                        rx_idx_q   <= byte_q;
                        rx_valid_q <= 1'b1;
                    end
                end else if (fall) begin
                    sclk_q <= 1'b0;
                    if (half_n == two_n) begin
                        mosi_q <= 1'b0;
                    end else if (bit_q == 3'd7) begin
                        bit_q   <= '0;
                        byte_q  <= byte_q + 3'd1;
                        tx_sr_q <= tx_byte_i[6:0];
                        mosi_q  <= tx_byte_i[7];
                    end else begin
                        bit_q   <= bit_q + 3'd1;
                        tx_sr_q <= {tx_sr_q[5:0], 1'b0};
                        mosi_q  <= tx_sr_q[6];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/acl_spi_sampler.sv
// acl_spi_sampler: configures the ADXL362 once, then polls X/Y/Z at a fixed rate over SPI
module acl_spi_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int STARTUP_CYC   = 500000,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int CS_GAP        = 8
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic        enable_i,
    input  logic        ACL_MISO,
    output logic        ACL_MOSI,
    output logic        ACL_SCLK,
    output logic        ACL_CSN,
    output logic [31:0] acl_data_o,
    output logic        data_valid_o,
    output logic        cfg_done_o,
    output logic        busy_o
);
    import acl_spi_pkg::*;

    localparam int SW = $clog2(STARTUP_CYC + 1);
    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam int GW = $clog2(CS_GAP + 1);

    state_e        state_q, state_d;
    logic [SW-1:0] st_cnt_q, st_cnt_d;
    logic [PW-1:0] smp_cnt_q, smp_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [23:0]   shadow_q, shadow_d, data_q;
    logic          busy_q, valid_q, cfg_done_q;
    logic          st_done, smp_done, gap_done, start, cfg_sel, rd_end;
    logic [2:0]    n_bytes, tx_idx, rx_idx;
    logic [7:0]    tx_byte, rx_byte;
    logic          sh_done, rx_valid;

    acl_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .pclk_i     (pclk_i),
        .presetn_i  (presetn_i),
        .start_i    (start),
        .n_bytes_i  (n_bytes),
        .tx_byte_i  (tx_byte),
        .tx_idx_o   (tx_idx),
        .rx_byte_o  (rx_byte),
        .rx_idx_o   (rx_idx),
        .rx_valid_o (rx_valid),
        .done_o     (sh_done),
        .miso_i     (ACL_MISO),
        .mosi_o     (ACL_MOSI),
        .sclk_o     (ACL_SCLK),
        .csn_o      (ACL_CSN)
    );

    // Sequencer: next state, frame start and the three timers
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        st_done   = st_cnt_q == SW'(STARTUP_CYC - 1);
        smp_done  = smp_cnt_q == PW'(SAMPLE_PERIOD - 1);
        gap_done  = gap_cnt_q == GW'(CS_GAP - 1);
        cfg_sel   = state_q == STARTUP || state_q == CFG_FRAME;
        n_bytes   = cfg_sel ? CFG_BYTES : RD_BYTES;
        tx_byte   = frame_byte(cfg_sel, tx_idx);
        rd_end    = sh_done && state_q == RD_FRAME;
        case (state_q)
            STARTUP:   if (st_done && enable_i) begin
                           start   = 1'b1;
                           state_d = CFG_FRAME;
                       end
            CFG_FRAME: if (sh_done) state_d = GAP;
            GAP:       if (gap_done) state_d = WAIT;
            WAIT:      if (smp_done && enable_i) begin
                           start   = 1'b1;
                           state_d = RD_FRAME;
                       end
            RD_FRAME:  if (sh_done) state_d = GAP;
            default:   state_d = STARTUP;
        endcase
        st_cnt_d  = st_done ? st_cnt_q : st_cnt_q + 1'b1;
        gap_cnt_d = state_q == GAP ? gap_cnt_q + 1'b1 : '0;
        smp_cnt_d = (start && state_q == WAIT) ? '0 : smp_done ? smp_cnt_q : smp_cnt_q + 1'b1;
    end

    // Shadow collects X, Y, Z (bytes 2..4 of a read frame) until the frame ends
    always_comb begin
        shadow_d = shadow_q;
        if (rx_valid && state_q == RD_FRAME) begin
            if (rx_idx == 3'd2) shadow_d[23:16] = rx_byte;
            if (rx_idx == 3'd3) shadow_d[15:8]  = rx_byte;
            if (rx_idx == 3'd4) shadow_d[7:0]   = rx_byte;
        end
    end

    // State, timers and output registers; the sample word updates only at a read-frame CSN rise
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q    <= STARTUP;
            st_cnt_q   <= '0;
            smp_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            st_cnt_q   <= st_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shadow_q   <= shadow_d;
            busy_q     <= start | (busy_q & ~sh_done);
            valid_q    <= rd_end;
            if (rd_end)
                data_q <= shadow_q;
            if (sh_done && state_q == CFG_FRAME)
                cfg_done_q <= 1'b1;
        end
    end

    assign acl_data_o   = {8'h00, data_q};
    assign data_valid_o = valid_q;
    assign cfg_done_o   = cfg_done_q;
    assign busy_o       = busy_q;

endmodule
